// File: rtl/enc16_4_seq_if.sv
// Handshake bundle for the 16:4 priority encoder: input word stream, encoded
// output stream and the error counter.
interface enc16_4_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_code;
  logic        out_zero;
  logic        out_multi;
  logic [7:0]  err_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_code, out_zero, out_multi, err_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_code, out_zero, out_multi, err_cnt
  );
endinterface

// File: rtl/enc16_4_seq.sv
// Registered 16:4 encoder with valid/ready handshake, zero/multi-bit flags and
// a saturating count of words that were not one-hot.
module enc16_4_seq #(
  parameter int PRIORITY_HIGH = 1
) (
  input  logic          clk,
  input  logic          rst,
  enc16_4_seq_if.slave  bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state_q, state_d;
  logic        in_xfer, out_xfer;
  logic [3:0]  code_p0;
  logic        zero_p0, multi_p0;
  logic [3:0]  code_p1;
  logic        zero_p1, multi_p1;
  logic [7:0]  err_p1;

  function automatic logic [3:0] pick_index(input logic [15:0] d);
    logic [3:0] idx;
    idx = 4'd0;
    // Scan toward the winning end so the last hit is the priority bit.
    if (PRIORITY_HIGH != 0) begin
      for (int i = 0; i < 16; i++)
        if (d[i]) idx = 4'(i);
    end else begin
      for (int i = 15; i >= 0; i--)
        if (d[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign bus.in_ready = !rst && (state_q == EMPTY || bus.out_ready);
  assign in_xfer      = bus.in_valid && bus.in_ready;
  assign out_xfer     = (state_q == FULL) && bus.out_ready;

  // Stage p0: combinational encode of the incoming word
  assign code_p0  = pick_index(bus.in_data);
  assign zero_p0  = (bus.in_data == 16'h0000);
  assign multi_p0 = ((bus.in_data & (bus.in_data - 16'd1)) != 16'h0000);

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (in_xfer) state_d = FULL;
      FULL:    if (out_xfer && !in_xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Stage p1: output register, held until the downstream takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      code_p1  <= 4'd0;
      zero_p1  <= 1'b0;
      multi_p1 <= 1'b0;
      err_p1   <= 8'd0;
    end else begin
      state_q <= state_d;
      if (in_xfer) begin
        code_p1  <= code_p0;
        zero_p1  <= zero_p0;
        multi_p1 <= multi_p0;
        if (zero_p0 || multi_p0) err_p1 <= sat_inc(err_p1);
      end
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_code  = code_p1;
  assign bus.out_zero  = zero_p1;
  assign bus.out_multi = multi_p1;
  assign bus.err_cnt   = err_p1;

endmodule

// File: doc/enc16_4_seq.md
ENC16_4_SEQ -- requirements
Module: enc16_4_seq

Interface
REQ-001 The block SHALL have parameter PRIORITY_HIGH, default 1; 1 = highest set bit wins, 0 = lowest set bit wins.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1, in_data valid.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept in_data this cycle.
REQ-006 The block SHALL have port in_data, input, 16, one-hot word to encode (the inverse of the team's 4:16 decoder output).
REQ-007 The block SHALL have port out_valid, output, 1, out_* fields valid.
REQ-008 The block SHALL have port out_ready, input, 1, downstream accepts out_* this cycle.
REQ-009 The block SHALL have port out_code, output, 4, encoded bit index.
REQ-010 The block SHALL have port out_zero, output, 1, accepted word had no bit set.
REQ-011 The block SHALL have port out_multi, output, 1, accepted word had more than one bit set.
REQ-012 The block SHALL have port err_cnt, output, 8, saturating count of accepted non-one-hot words.

Function
REQ-013 The block SHALL implement a two-state output FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 The block SHALL define an input transfer as in_valid && in_ready at a rising edge, and an output transfer as out_valid && out_ready.
REQ-015 The block SHALL drive in_ready = !rst && (state==EMPTY || out_ready), combinationally.
REQ-016 The block SHALL have latency 1: a word transferred at edge N drives out_* from edge N until its output transfer.
REQ-017 The block SHALL make transitions EMPTY->FULL on input transfer, FULL->EMPTY on output transfer with no input transfer, and FULL->FULL on simultaneous output and input transfer (new word loaded, no bubble).
REQ-018 The block SHALL hold out_code, out_zero, out_multi stable while out_valid=1 and out_ready=0.
REQ-019 The block SHALL ignore in_data when in_valid=0 or in_ready=0 (no state or counter change).
REQ-020 For a one-hot word with bit k set, the block SHALL produce out_code=k, out_zero=0, out_multi=0.
REQ-021 For in_data=16'h0000, the block SHALL produce out_code=0, out_zero=1, out_multi=0.
REQ-022 For two or more set bits, the block SHALL produce out_multi=1, out_zero=0, and out_code=index of highest set bit when PRIORITY_HIGH=1, lowest when PRIORITY_HIGH=0.
REQ-023 The block SHALL increment err_cnt by 1 on each input transfer whose word is zero or multi-bit, saturating at 8'hFF (no wrap).
REQ-024 The block SHALL update err_cnt at the same edge the word is loaded into the output register.
REQ-025 The block SHALL keep out_* at their last values when returning to EMPTY; only out_valid qualifies them.

Reset
REQ-026 While rst=1 at a rising edge, the block SHALL force state=EMPTY, out_valid=0, out_code=0, out_zero=0, out_multi=0, err_cnt=0.
REQ-027 The block SHALL hold in_ready=0 during any cycle with rst=1, so no input transfer occurs.
REQ-028 Reset asserted while FULL and stalled SHALL discard the held word; out_valid=0 on the following cycle with no output transfer counted.
REQ-029 The block SHALL accept a word on the first edge after rst deasserts if in_valid=1.

Verification
REQ-030 The bench SHALL sweep in_data=16'h0001<<k for k=0..15 with out_ready=1 -> out_code=k one cycle later, flags 0, err_cnt=0.
REQ-031 The bench SHALL drive in_data=16'h0000 then 16'h8101 (PRIORITY_HIGH=1) -> (code 0, zero=1), then (code 15, multi=1), err_cnt=2; with PRIORITY_HIGH=0 the second word -> code 0.
REQ-032 The bench SHALL load 16'h0400, hold out_ready=0 for 5 cycles while in_valid=1 with 16'h0002 -> out_code=10 stable, in_ready=0; on out_ready=1 -> 16'h0002 transferred same edge, out_code=1 next cycle, no bubble.
REQ-033 The bench SHALL stream 300 back-to-back words of 16'hFFFF -> err_cnt reaches 8'hFF and stays 8'hFF; one output per cycle.
REQ-034 The bench SHALL assert rst for one cycle while FULL with out_ready=0 -> out_valid=0, err_cnt=0, in_ready=0 during rst, in_ready=1 after.
REQ-035 The bench SHALL feed every out_code through the team's 4:16 decoder and check decoded value equals the one-hot in_data for all valid one-hot words.
